// File: rtl/median_pkg.sv
// Shared pixel/column types for the median filter pipeline (feeder, window buffer, sorter).
package median_pkg;

    localparam int unsigned PIX_W = 9;
    localparam int unsigned WIN   = 11;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [WIN-1:0]   col_t;

endpackage

// File: rtl/median_line_ram.sv
// Single-port read-first line memory with a registered read port.
module median_line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 9,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wr_data;
        end
    end

    // The read register returns the pre-write contents and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/median_column_feeder.sv
// Raster-order line buffer: turns one pixel per cycle into one ROWS-tall vertical column.
module median_column_feeder #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned PIX_W = median_pkg::PIX_W,
    parameter int unsigned ROWS  = median_pkg::WIN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_sof,
    input  logic                  in_valid,
    input  logic [PIX_W-1:0]      in_pixel,
    output logic                  col_valid,
    output logic [ROWS*PIX_W-1:0] col_out,
    output logic [11:0]           col_x,
    output logic                  col_eol
);

    localparam int unsigned XW    = 12;
    localparam int unsigned LINES = ROWS - 1;
    localparam int unsigned LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [XW-1:0]    x_cnt;
    logic [XW-1:0]    x_eff;
    logic [RW-1:0]    rows_seen;
    logic [RW-1:0]    rows_eff;
    logic [LW-1:0]    wr_line;
    logic [LW-1:0]    wr_eff;
    logic [LW-1:0]    wr_q;
    logic             eol;
    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] tap [LINES];
    logic [ROWS*PIX_W-1:0] col_c;
    int unsigned      sel;

    // A start-of-frame pixel is placed at x=0 of row 0 regardless of counter state.
    always_comb begin
        x_eff    = x_cnt;
        rows_eff = rows_seen;
        wr_eff   = wr_line;
        if (in_sof) begin
            x_eff    = '0;
            rows_eff = '0;
            wr_eff   = '0;
        end
        eol = (x_eff == XW'(IMG_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt     <= '0;
            rows_seen <= '0;
            wr_line   <= '0;
            wr_q      <= '0;
            pix_q     <= '0;
            col_valid <= 1'b0;
            col_x     <= '0;
            col_eol   <= 1'b0;
        end else begin
            col_valid <= 1'b0;
            if (in_valid) begin
                pix_q     <= in_pixel;
                wr_q      <= wr_eff;
                col_valid <= (rows_eff == RW'(LINES));
                col_x     <= x_eff;
                col_eol   <= eol;
                if (eol) begin
                    x_cnt   <= '0;
                    wr_line <= (wr_eff == LW'(LINES - 1)) ? '0 : wr_eff + LW'(1);
                    rows_seen <= (rows_eff == RW'(LINES)) ? rows_eff : rows_eff + RW'(1);
                end else begin
                    x_cnt     <= x_eff + XW'(1);
                    wr_line   <= wr_eff;
                    rows_seen <= rows_eff;
                end
            end
        end
    end

    for (genvar i = 0; i < LINES; i++) begin : g_line
        median_line_ram #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .en      (in_valid),
            .we      (in_valid && (wr_eff == LW'(i))),
            .addr    (AW'(x_eff)),
            .wr_data (in_pixel),
            .rd_data (tap[i])
        );
    end

    // Slot k (k lines above) comes from memory (wr_q + LINES - k) mod LINES.
    always_comb begin
        col_c = '0;
        sel   = 0;
        col_c[PIX_W-1:0] = pix_q;
        for (int k = 1; k < ROWS; k++) begin
            sel = 32'(wr_q) + LINES - 32'(k);
            if (sel >= LINES) begin
                sel = sel - LINES;
            end
            col_c[k*PIX_W +: PIX_W] = tap[LW'(sel)];
        end
    end

    assign col_out = col_c;

endmodule

// File: tb/tb_median_column_feeder.sv
// Randomized self-checking bench for median_column_feeder against a frame-array reference model.
module tb_median_column_feeder;

    localparam int W = 4;
    localparam int P = 9;
    localparam int R = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_sof;
    logic           in_valid;
    logic [P-1:0]   in_pixel;
    logic           col_valid;
    logic [R*P-1:0] col_out;
    logic [11:0]    col_x;
    logic           col_eol;

    median_column_feeder #(.IMG_W(W), .PIX_W(P), .ROWS(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .col_valid (col_valid),
        .col_out   (col_out),
        .col_x     (col_x),
        .col_eol   (col_eol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int dut_strobes = 0;

    // Reference model: every pixel of the current frame, addressed by (row, x).
    logic [P-1:0]   frame [0:63][0:W-1];
    int             mr, mx;
    logic [R*P-1:0] e_col;
    logic [11:0]    e_x;
    logic           e_eol, e_valid, held_ok;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic [P-1:0] p);
        @(negedge clk);
        in_valid = v;
        in_sof   = s & v;
        in_pixel = p;
        if (v) begin
            if (s) begin
                mr = 0;
                mx = 0;
            end
            frame[mr][mx] = p;
            e_valid = (mr >= R - 1);
            if (e_valid) begin
                e_col = '0;
                for (int k = 0; k < R; k++) e_col[k*P +: P] = frame[mr-k][mx];
                e_x     = 12'(mx);
                e_eol   = (mx == W - 1);
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            mx++;
            if (mx == W) begin
                mx = 0;
                if (mr < 63) mr++;
            end
        end else begin
            e_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (col_valid === 1'b1) dut_strobes++;
        check("col_valid", 128'(col_valid), 128'(e_valid));
        if (held_ok) begin
            check("col_out", 128'(col_out), 128'(e_col));
            check("col_x",   128'(col_x),   128'(e_x));
            check("col_eol", 128'(col_eol), 128'(e_eol));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", 128'(col_valid), 128'(0));
        check("rst_col_x", 128'(col_x), 128'(0));
        check("rst_col_out", 128'(col_out), 128'(0));
        check("rst_col_eol", 128'(col_eol), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        mr = 0; mx = 0;
        e_col = '0; e_x = '0; e_eol = 1'b0; e_valid = 1'b0; held_ok = 1'b1;
    endtask

    // mode 0: dense pattern, 1: pattern with alternating gaps, 2: random pixels with random gaps
    task automatic send_frame(input int rows, input int mode);
        logic [P-1:0] p;
        for (int r = 0; r < rows; r++) begin
            for (int x = 0; x < W; x++) begin
                p = (mode == 2) ? P'($urandom_range(0, 511)) : P'(r * 16 + x);
                if (mode == 2 && $urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, P'($urandom));
                cycle(1'b1, (r == 0 && x == 0), p);
                if (mode == 1) cycle(1'b0, 1'b0, P'($urandom));
                if (mode == 0 && r == 10 && x == 2) begin
                    check("r10x2_cur",  128'(col_out[8:0]),   128'(9'h0A2));
                    check("r10x2_up1",  128'(col_out[17:9]),  128'(9'h092));
                    check("r10x2_up10", 128'(col_out[98:90]), 128'(9'h002));
                end
            end
        end
    endtask

    initial begin
        logic [P-1:0] sp;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        repeat (3) @(posedge clk);
        do_reset();

        dut_strobes = 0;
        send_frame(12, 0);
        check("strobes_dense", 128'(dut_strobes), 128'(8));

        dut_strobes = 0;
        send_frame(12, 1);
        check("strobes_gapped", 128'(dut_strobes), 128'(8));

        // Restart the frame at row 11, x=1.
        send_frame(11, 0);
        cycle(1'b1, 1'b0, P'(9'h0B0));
        sp = P'($urandom_range(0, 511));
        dut_strobes = 0;
        cycle(1'b1, 1'b1, sp);
        for (int n = 1; n < 11 * W; n++) begin
            cycle(1'b1, 1'b0, P'($urandom_range(0, 511)));
            if (n == 10 * W) check("sof_oldest", 128'(col_out[98:90]), 128'(sp));
        end
        check("strobes_after_sof", 128'(dut_strobes), 128'(W));

        // Reset pulse in the middle of row 10.
        send_frame(10, 2);
        cycle(1'b1, 1'b0, P'($urandom_range(0, 511)));
        cycle(1'b1, 1'b0, P'($urandom_range(0, 511)));
        do_reset();
        dut_strobes = 0;
        for (int n = 0; n < 11 * W; n++) cycle(1'b1, 1'b0, P'($urandom_range(0, 511)));
        check("strobes_after_rst", 128'(dut_strobes), 128'(W));

        // Long frame that wraps the ring pointer.
        dut_strobes = 0;
        send_frame(25, 2);
        repeat (3) cycle(1'b0, 1'b0, '0);
        check("strobes_wrap", 128'(dut_strobes), 128'(15 * W));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
